// File: rtl/rwt_dac_stream_source.sv
// AXI-Stream to per-channel DAC sample source: FIFO-buffered, primed, unpacks words onto enabled lanes.
// Optional RWT_DAC_SRC_HOLD_LAST_EN: on underflow dac_data holds its last value instead of going to 0.
module rwt_dac_stream_source #(
   parameter int MAX_CHANNELS = 4,
   parameter int FIFO_DEPTH   = 16,
   parameter int PRIME_LEVEL  = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [MAX_CHANNELS-1:0]    dac_enable,
   input  logic [MAX_CHANNELS-1:0]    dac_valid,
   output logic [MAX_CHANNELS*16-1:0] dac_data,
   input  logic [MAX_CHANNELS*16-1:0] s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       clr_underflow,
   output logic                       underflow,
   output logic [31:0]                underflow_count,
   output logic                       running
);
   localparam int DW = MAX_CHANNELS * 16;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                  state;
   logic [MAX_CHANNELS-1:0] mask;
   logic [DW-1:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [CW-1:0]           level;
   logic                    full;
   logic                    empty;
   logic                    enabled;
   logic                    strobe;
   logic                    flush;
   logic                    push;
   logic                    pop;
   logic                    uf_event;

   assign full          = (level == CW'(FIFO_DEPTH));
   assign empty         = (level == '0);
   assign enabled       = |dac_enable;
   assign strobe        = |(dac_valid & mask);
   assign s_axis_tready = (state != IDLE) && !full;
   assign flush         = (state == IDLE) || !enabled;
   assign push          = s_axis_tvalid && s_axis_tready && !flush;
   assign pop           = (state == RUN) && enabled && strobe && !empty;
   assign uf_event      = (state == RUN) && enabled && strobe && empty;
   assign running       = (state == RUN);

   // Lane j of the word lands on the channel holding the j-th set mask bit.
   function automatic logic [DW-1:0] unpack(input logic [DW-1:0] word,
                                            input logic [MAX_CHANNELS-1:0] m);
      logic [DW-1:0] res;
      int            lane;
      res  = '0;
      lane = 0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         if (m[i]) begin
            res[16*i +: 16] = word[16*lane +: 16];
            lane++;
         end
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s_axis_tdata;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + CW'(1);
            2'b01:   level <= level - CW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         mask     <= '0;
         dac_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               dac_data <= '0;
               if (enabled) begin
                  mask  <= dac_enable;
                  state <= PRIME;
               end
            end
            PRIME: begin
               dac_data <= '0;
               if (!enabled) begin
                  state <= IDLE;
               end else if (level >= CW'(PRIME_LEVEL)) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!enabled) begin
                  state    <= IDLE;
                  dac_data <= '0;
               end else if (pop) begin
                  dac_data <= unpack(mem[rd_ptr], mask);
               end else if (uf_event) begin
`ifdef RWT_DAC_SRC_HOLD_LAST_EN
                  dac_data <= dac_data;
`else
                  dac_data <= '0;
`endif
               end
            end
            default: begin
               state    <= IDLE;
               dac_data <= '0;
            end
         endcase
      end
   end

   // A clear coinciding with an underflow leaves that one event recorded.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         underflow       <= 1'b0;
         underflow_count <= '0;
      end else if (clr_underflow) begin
         underflow       <= uf_event;
         underflow_count <= uf_event ? 32'd1 : 32'd0;
      end else if (uf_event) begin
         underflow <= 1'b1;
         if (underflow_count != '1) begin
            underflow_count <= underflow_count + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_rwt_dac_stream_source.sv
// Directed bench for rwt_dac_stream_source (MAX_CHANNELS=4, FIFO_DEPTH=16, PRIME_LEVEL=4).
module tb_rwt_dac_stream_source;
   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  dac_enable;
   logic [3:0]  dac_valid;
   logic [63:0] dac_data;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        clr_underflow;
   logic        underflow;
   logic [31:0] underflow_count;
   logic        running;

   int compared   = 0;
   int mismatched = 0;

`ifdef RWT_DAC_SRC_HOLD_LAST_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   rwt_dac_stream_source #(
      .MAX_CHANNELS(4),
      .FIFO_DEPTH  (16),
      .PRIME_LEVEL (4)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .dac_enable     (dac_enable),
      .dac_valid      (dac_valid),
      .dac_data       (dac_data),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .clr_underflow  (clr_underflow),
      .underflow      (underflow),
      .underflow_count(underflow_count),
      .running        (running)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mkw(input int k);
      logic [15:0] b;
      b = 16'(k * 4) + 16'h4000;
      return {b + 16'd3, b + 16'd2, b + 16'd1, b};
   endfunction

   logic [63:0] words [4];
   logic [63:0] q [$];
   logic [63:0] exp_w;
   bit          do_pop;
   int          sent;

   initial begin
      words[0] = 64'h0004_0003_0002_0001;
      words[1] = 64'h1114_1113_1112_1111;
      words[2] = 64'h2224_2223_2222_2221;
      words[3] = 64'h3334_3333_3332_3331;
      rstn = 1'b0; dac_enable = '0; dac_valid = '0; s_axis_tdata = '0;
      s_axis_tvalid = 1'b0; clr_underflow = 1'b0;
      #12;
      chk("rst_data", dac_data, 0);
      chk("rst_tready", 64'(s_axis_tready), 0);
      chk("rst_uf", 64'(underflow), 0);
      chk("rst_ufcnt", 64'(underflow_count), 0);
      chk("rst_running", 64'(running), 0);
      rstn = 1'b1;
      step();
      dac_enable = 4'hF;
      step();
      chk("prime_tready", 64'(s_axis_tready), 1);
      chk("prime_running", 64'(running), 0);

      // Prime with W0..W3; a strobe during PRIME must be ignored.
      for (int k = 0; k < 4; k++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = words[k];
         dac_valid = (k == 1) ? 4'hF : 4'h0;
         step();
         if (k == 1) begin
            chk("prime_strobe_data", dac_data, 0);
            chk("prime_strobe_uf", 64'(underflow), 0);
         end
      end
      s_axis_tvalid = 1'b0; dac_valid = '0;
      chk("prime_not_yet_run", 64'(running), 0);
      step();
      chk("run_after_prime", 64'(running), 1);
      dac_valid = 4'hF; step(); dac_valid = '0;
      chk("first_word", dac_data, 64'h0004_0003_0002_0001);
      step();
      chk("data_holds", dac_data, 64'h0004_0003_0002_0001);
      for (int k = 1; k < 4; k++) begin
         dac_valid = 4'hF; step(); dac_valid = '0;
         chk("pop_word", dac_data, words[k]);
      end

      // Three strobes on an empty FIFO.
      dac_valid = 4'hF;
      step(); step(); step();
      dac_valid = '0;
      chk("uf_flag", 64'(underflow), 1);
      chk("uf_count3", 64'(underflow_count), 3);
      chk("uf_data", dac_data, HOLD ? words[3] : 64'h0);
      chk("uf_still_run", 64'(running), 1);
      clr_underflow = 1'b1; dac_valid = 4'hF; step();
      clr_underflow = 1'b0; dac_valid = '0;
      chk("clr_event_count", 64'(underflow_count), 1);
      chk("clr_event_flag", 64'(underflow), 1);

      // Drop enable: IDLE, underflow retained until cleared.
      dac_enable = '0; step();
      chk("idle_running", 64'(running), 0);
      chk("idle_tready", 64'(s_axis_tready), 0);
      chk("idle_data", dac_data, 0);
      chk("idle_uf_kept", 64'(underflow), 1);
      chk("idle_ufcnt_kept", 64'(underflow_count), 1);
      clr_underflow = 1'b1; step(); clr_underflow = 1'b0;
      chk("clr_flag", 64'(underflow), 0);
      chk("clr_count", 64'(underflow_count), 0);

      // Sparse mask 1010; later mask change to 1110 must be ignored.
      dac_enable = 4'b1010; step();
      s_axis_tvalid = 1'b1;
      s_axis_tdata = 64'hDDDD_CCCC_BBBB_AAAA; step();
      s_axis_tdata = 64'h5555_6666_7777_8888; step();
      s_axis_tdata = 64'h5555_6666_7777_8888; step();
      s_axis_tdata = 64'h5555_6666_7777_8888; step();
      s_axis_tvalid = 1'b0;
      step();
      chk("mask_run", 64'(running), 1);
      dac_enable = 4'b1110;
      dac_valid = 4'b0001; step();
      chk("unmasked_strobe", dac_data, 0);
      dac_valid = 4'b0010; step(); dac_valid = '0;
      chk("sparse_unpack", dac_data, 64'hBBBB_0000_AAAA_0000);
      chk("mask_change_run", 64'(running), 1);

      // Five words buffered, then drop enable and re-prime with fresh data.
      s_axis_tvalid = 1'b1; s_axis_tdata = 64'h9999_9999_9999_9999;
      step(); step();
      s_axis_tvalid = 1'b0;
      dac_enable = '0; step();
      chk("flush_running", 64'(running), 0);
      chk("flush_tready", 64'(s_axis_tready), 0);
      chk("flush_data", dac_data, 0);
      dac_enable = 4'hF; step();
      chk("reprime_tready", 64'(s_axis_tready), 1);
      for (int k = 0; k < 3; k++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = mkw(100 + k); step();
      end
      s_axis_tvalid = 1'b0;
      step();
      chk("reprime_no_stale", 64'(running), 0);
      s_axis_tvalid = 1'b1; s_axis_tdata = mkw(103); step();
      s_axis_tvalid = 1'b0;
      step();
      chk("reprime_run", 64'(running), 1);
      for (int k = 0; k < 4; k++) begin
         dac_valid = 4'hF; step(); dac_valid = '0;
         chk("reprime_word", dac_data, mkw(100 + k));
      end

      // Fill to full, then stream 40 words through with wrap-around.
      sent = 0;
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 40 && s_axis_tready; c++) begin
         s_axis_tdata = mkw(sent); q.push_back(mkw(sent)); sent++;
         step();
      end
      chk("fill_count", 64'(sent), 16);
      chk("full_tready", 64'(s_axis_tready), 0);
      s_axis_tdata = mkw(sent);
      dac_valid = 4'hF; exp_w = q.pop_front(); step(); dac_valid = '0;
      chk("tready_back", 64'(s_axis_tready), 1);
      chk("pop_after_full", dac_data, exp_w);
      for (int c = 0; c < 200 && (sent < 40 || q.size() > 0); c++) begin
         do_pop = (q.size() > 0);
         dac_valid = do_pop ? 4'hF : 4'h0;
         if (do_pop) exp_w = q.pop_front();
         if (sent < 40 && s_axis_tready) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = mkw(sent);
            q.push_back(mkw(sent)); sent++;
         end else begin
            s_axis_tvalid = 1'b0;
         end
         step();
         if (do_pop) chk("wrap_order", dac_data, exp_w);
      end
      dac_valid = '0; s_axis_tvalid = 1'b0;
      chk("wrap_sent", 64'(sent), 40);
      chk("wrap_drained", 64'(q.size()), 0);
      chk("wrap_no_uf", 64'(underflow), 0);

      // Asynchronous reset between edges while running.
      dac_valid = 4'hF; step(); dac_valid = '0;
      s_axis_tvalid = 1'b1; s_axis_tdata = mkw(7); step();
      s_axis_tdata = mkw(8); step();
      s_axis_tvalid = 1'b0;
      dac_valid = 4'hF; step(); dac_valid = '0;
      chk("pre_rst_data", dac_data, mkw(7));
      chk("pre_rst_uf", 64'(underflow), 1);
      #2 rstn = 1'b0;
      #1;
      chk("arst_data", dac_data, 0);
      chk("arst_tready", 64'(s_axis_tready), 0);
      chk("arst_uf", 64'(underflow), 0);
      chk("arst_ufcnt", 64'(underflow_count), 0);
      chk("arst_running", 64'(running), 0);
      step();
      rstn = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/rwt_dac_stream_source.md
Name: rwt_dac_stream_source

Overview:
- Synthesizable producer side of the per-channel DAC sample interface (clk/data/enable/valid, 16 bits per channel).
- Accepts packed sample words from an AXI-Stream source and buffers them in a FIFO.
- Unpacks each word onto the enabled channel lanes and drives one word per DAC valid strobe.
- Sits between the DMA/stream fabric and the DAC core, and reports underflow to software.

Parameters:
- MAX_CHANNELS, 4, number of 16-bit channel lanes on the DAC interface.
- FIFO_DEPTH, 16, FIFO depth in words; power of two, minimum 4.
- PRIME_LEVEL, 4, FIFO occupancy required before streaming starts; 1..FIFO_DEPTH.

Ports:
- clk  in  1  DAC interface clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- dac_enable  in  MAX_CHANNELS  per-channel enable from the DAC core.
- dac_valid  in  MAX_CHANNELS  per-channel sample request strobe.
- dac_data  out  MAX_CHANNELS*16  channel i occupies bits [16*i +: 16].
- s_axis_tdata  in  MAX_CHANNELS*16  packed samples; lane j = bits [16*j +: 16].
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- clr_underflow  in  1  synchronous clear of the underflow status.
- underflow  out  1  sticky underflow flag.
- underflow_count  out  32  saturating underflow event counter.
- running  out  1  high while in RUN.

Behaviour:
- Reset (rstn=0, asynchronous):
  - dac_data=0, s_axis_tready=0, underflow=0, underflow_count=0, running=0.
  - FIFO empty, state IDLE, latched mask=0.
- strobe = |(dac_valid & latched_mask).
- FSM:
  - IDLE: tready=0, FIFO held empty, dac_data=0. If dac_enable!=0, latch mask=dac_enable and go to PRIME.
  - PRIME: tready=!full. Strobes are ignored and dac_data stays 0. Go to RUN on the cycle after occupancy>=PRIME_LEVEL.
  - RUN: tready=!full, running=1. On a strobe, pop one word; dac_data updates on the next clock edge, so latency is 1 cycle from strobe to data.
  - From PRIME or RUN: dac_enable==0 -> IDLE on the next edge. FIFO is flushed, dac_data=0, running=0. Underflow status is retained.
- Mask changes while in PRIME or RUN are ignored until the block returns to IDLE.
- Unpacking:
  - M = popcount(latched mask).
  - Input lane j (j<M) goes to the channel holding the j-th set bit of the mask, counted from bit 0.
  - Lanes >= M are discarded.
  - Disabled channels always output 0.
- FIFO:
  - Push when s_axis_tvalid & s_axis_tready.
  - Push and pop in the same cycle is legal when occupancy is between 1 and FIFO_DEPTH.
  - When empty, there is no bypass: a push and a strobe in the same cycle is an underflow, and the pushed word is stored.
  - Full -> tready=0.
  - Pointer wrap-around is modulo FIFO_DEPTH.
- Underflow:
  - Trigger: strobe in RUN with the FIFO empty.
  - underflow is set, underflow_count increments and saturates at 0xFFFFFFFF.
  - dac_data is driven to 0, unless the optional feature is compiled in.
  - FSM stays in RUN and does not re-prime.
- clr_underflow:
  - Clears the flag and the counter.
  - If it coincides with an underflow event, the result is underflow=1, count=1.
- Reset mid-operation aborts immediately to the reset values listed above.

Optional Feature:
- Macro: RWT_DAC_SRC_HOLD_LAST_EN.
- Defined: on underflow, dac_data holds its previous value instead of going to 0.
  - On the first underflow after PRIME, the held value is 0.
- Undefined: underflow drives 0 on all channels.
- Underflow counting is identical in both builds.

Test Plan:
- Reset, then enable=4'b1111 with PRIME_LEVEL=4; push words W0..W3 with W0 lanes = 0x0001,0x0002,0x0003,0x0004 -> running asserts after the 4th push. The first strobe gives dac_data[15:0]=0x0001 … [63:48]=0x0004 one cycle later.
- enable=4'b1010; push a word with lanes 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> ch1=0xAAAA, ch3=0xBBBB, ch0=ch2=0.
- In RUN with the FIFO empty, issue 3 strobes -> underflow=1, count=3, dac_data=0. With RWT_DAC_SRC_HOLD_LAST_EN, dac_data holds the last popped word. Then pulse clr_underflow together with a 4th empty strobe -> count=1, underflow=1.
- Hold tvalid=1 with no strobes, FIFO_DEPTH=16 -> tready drops after 16 accepted words. One strobe -> tready returns high the next cycle. Data order is preserved across pointer wrap for 40 words.
- Drop enable to 0 mid-RUN with 5 words buffered -> IDLE next cycle, tready=0, dac_data=0. Re-enable -> PRIME starts from an empty FIFO and no stale word is emitted.
- Assert rstn=0 asynchronously between clock edges during RUN -> all outputs are at their reset values before the next edge.
